// File: rtl/param_ram.sv
// Parametrised single-port synchronous RAM with valid/ready requests, byte-lane
// writes, a 1-cycle registered read and a self-clearing INIT pass after reset.
module param_ram #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            DEPTH      = 4096,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      write,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic [DATA_WIDTH/8-1:0]   be,
  output logic [DATA_WIDTH-1:0]     out,
  output logic                      out_valid,
  output logic                      init_done
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       init_cnt;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   accept;
  logic [IDX_W-1:0]       idx;

  // Upper address bits are discarded: DEPTH is a power of two.
  assign idx    = IDX_W'(address % ADDR_WIDTH'(DEPTH));
  assign accept = req_valid & req_ready;

  // Storage: INIT sweep has the port to itself; afterwards byte-lane writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[init_cnt] <= INIT_VALUE;
      end else if (accept && write) begin
        for (int i = 0; i < BYTES; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= data[8*i +: 8];
        end
      end
    end
  end

  // Control FSM and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          out_valid <= 1'b0;
          init_cnt  <= init_cnt + IDX_W'(1);
          if (init_cnt == LAST_IDX) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          out_valid <= accept & ~write;
          if (accept && !write) out <= mem[idx];
        end
        default: begin
          state     <= ST_INIT;
          init_cnt  <= '0;
          req_ready <= 1'b0;
          init_done <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
